// File: rtl/frame_buffer_fifo_drain_pkg.sv
// Shared display constants and pixel/address types for the frame-buffer drain path.
package frame_buffer_fifo_drain_pkg;

    localparam int H_RES    = 640;
    localparam int V_RES    = 480;
    localparam int COLOR_W  = 3;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int ADDR_W   = $clog2(FB_DEPTH);

    typedef logic [COLOR_W-1:0] pixel_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    // Raster address after a write, wrapping back to 0 past the last pixel of the frame.
    function automatic addr_t next_addr(input addr_t addr, input addr_t last);
        return (addr == last) ? '0 : addr + addr_t'(1);
    endfunction

endpackage

// File: rtl/frame_buffer_fifo_drain_skid.sv
// Two-entry register FIFO holding pixels between the FIFO read port and the frame-buffer write port.
module pixel_skid_buffer
    import frame_buffer_fifo_drain_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [COLOR_W-1:0]   push_data,
    input  logic                 pop,
    output logic [1:0]           count,
    output logic [COLOR_W-1:0]   head
);

    pixel_t slot0;
    pixel_t slot1;

    // slot0 is always the oldest pixel; a pop shifts slot1 forward.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot0 <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        slot0 <= push_data;
                    else
                        slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd2) begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end else begin
                        slot0 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head = slot0;

endmodule

// File: rtl/frame_buffer_fifo_drain.sv
// Pops pixels from the rasterizer FIFO and writes them to the frame buffer in linear raster order.
module frame_buffer_fifo_drain
    import frame_buffer_fifo_drain_pkg::*;
#(
    parameter int FRAME_W = H_RES,
    parameter int FRAME_H = V_RES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fifo_empty,
    input  logic [COLOR_W-1:0]   fifo_dout,
    output logic                 fifo_rd_en,
    input  logic                 fb_grant,
    output logic                 fb_we,
    output logic [ADDR_W-1:0]    fb_addr,
    output logic [COLOR_W-1:0]   fb_data,
    input  logic                 frame_restart,
    output logic                 frame_done
);

    localparam addr_t LAST_ADDR = addr_t'(FRAME_W * FRAME_H - 1);

    logic       drain;
    logic       rd_pend;
    logic [1:0] count;
    logic [2:0] occupancy;
    pixel_t     head;
    addr_t      addr_cnt;

    // Occupancy counts buffered pixels after this cycle's drain plus the one still in flight.
    assign drain      = (count != 2'd0) && fb_grant;
    assign occupancy  = {1'b0, count} - {2'b00, drain} + {2'b00, rd_pend};
    assign fifo_rd_en = rst && !fifo_empty && (occupancy < 3'd2);

    assign fb_we   = drain;
    assign fb_data = head;
    assign fb_addr = addr_cnt;

    pixel_skid_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .push_data (fifo_dout),
        .pop       (drain),
        .count     (count),
        .head      (head)
    );

    // A restart overrides the increment but the last-pixel write still reports frame_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_pend    <= 1'b0;
            addr_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            rd_pend    <= fifo_rd_en;
            frame_done <= drain && (addr_cnt == LAST_ADDR);
            if (frame_restart)
                addr_cnt <= '0;
            else if (drain)
                addr_cnt <= next_addr(addr_cnt, LAST_ADDR);
        end
    end

endmodule

// File: tb/tb_frame_buffer_fifo_drain.sv
// Directed bench: a full-size instance plus a tiny 8x4 instance so frame wrap is reachable quickly.
module tb_frame_buffer_fifo_drain;
    import frame_buffer_fifo_drain_pkg::*;

    localparam int SMALL_W = 8;
    localparam int SMALL_H = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold_empty = 1'b1;
    logic fifo_empty;
    logic fb_grant = 1'b0;
    logic frame_restart = 1'b0;
    logic [COLOR_W-1:0] fifo_dout = '0;

    logic [1:0] rd_o;
    logic [1:0] we_o;
    logic [1:0] done_o;
    logic [ADDR_W-1:0]  addr_o [2];
    logic [COLOR_W-1:0] data_o [2];

    int popped = 0;
    int vectors = 0;
    int miscompares = 0;

    int issued = 0;
    int written = 0;
    int base = 0;
    bit last_rd = 1'b0;
    int exp_addr [2] = '{0, 0};
    bit done_pend [2] = '{1'b0, 1'b0};
    int depth [2] = '{H_RES * V_RES, SMALL_W * SMALL_H};

    assign fifo_empty = hold_empty;

    always #5 clk = ~clk;

    frame_buffer_fifo_drain dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (rd_o[0]),
        .fb_grant      (fb_grant),
        .fb_we         (we_o[0]),
        .fb_addr       (addr_o[0]),
        .fb_data       (data_o[0]),
        .frame_restart (frame_restart),
        .frame_done    (done_o[0])
    );

    frame_buffer_fifo_drain #(.FRAME_W(SMALL_W), .FRAME_H(SMALL_H)) dut_small (
        .clk           (clk),
        .rst           (rst),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (rd_o[1]),
        .fb_grant      (fb_grant),
        .fb_we         (we_o[1]),
        .fb_addr       (addr_o[1]),
        .fb_data       (data_o[1]),
        .frame_restart (frame_restart),
        .frame_done    (done_o[1])
    );

    function automatic logic [COLOR_W-1:0] color_of(input int idx);
        return COLOR_W'((idx % 7) + 1);
    endfunction

    // Standard (non-fall-through) FIFO source: data appears the cycle after the pop.
    always @(posedge clk) begin
        if (rd_o[0]) begin
            fifo_dout <= color_of(popped);
            popped    <= popped + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic grant, input logic empty, input logic restart);
        @(posedge clk);
        #1;
        fb_grant      = grant;
        hold_empty    = empty;
        frame_restart = restart;
    endtask

    // Model: pixels read but not yet written, in pop order, addressed by a wrapping raster counter.
    always @(negedge clk) begin : compare
        bit exp_we;
        bit exp_rd;
        int in_buf;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("reset rd_en[%0d]", i), 32'(rd_o[i]), 32'd0);
                checkOutput($sformatf("reset fb_we[%0d]", i), 32'(we_o[i]), 32'd0);
                checkOutput($sformatf("reset fb_addr[%0d]", i), 32'(addr_o[i]), 32'd0);
                checkOutput($sformatf("reset fb_data[%0d]", i), 32'(data_o[i]), 32'd0);
                checkOutput($sformatf("reset frame_done[%0d]", i), 32'(done_o[i]), 32'd0);
                exp_addr[i]  = 0;
                done_pend[i] = 1'b0;
            end
            issued  = 0;
            written = 0;
            last_rd = 1'b0;
            base    = popped;
        end else begin
            in_buf = issued - int'(last_rd) - written;
            exp_we = fb_grant && (in_buf > 0);
            exp_rd = !fifo_empty && ((issued - written - int'(exp_we)) < 2);
            for (int i = 0; i < 2; i++) begin
                checkOutput($sformatf("rd_en[%0d]", i), 32'(rd_o[i]), 32'(exp_rd));
                checkOutput($sformatf("fb_we[%0d]", i), 32'(we_o[i]), 32'(exp_we));
                checkOutput($sformatf("fb_addr[%0d]", i), 32'(addr_o[i]), 32'(exp_addr[i]));
                checkOutput($sformatf("frame_done[%0d]", i), 32'(done_o[i]), 32'(done_pend[i]));
                if (exp_we)
                    checkOutput($sformatf("fb_data[%0d]", i), 32'(data_o[i]), 32'(color_of(base + written)));
                done_pend[i] = exp_we && (exp_addr[i] == depth[i] - 1);
                if (frame_restart)
                    exp_addr[i] = 0;
                else if (exp_we)
                    exp_addr[i] = (exp_addr[i] == depth[i] - 1) ? 0 : exp_addr[i] + 1;
            end
            written += int'(exp_we);
            issued  += int'(exp_rd);
            last_rd  = exp_rd;
        end
    end

    task automatic waitWrite(input int inst, input int addr, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            #1;
            if (we_o[inst] && (int'(addr_o[inst]) == addr))
                found = 1'b1;
        end
        checkOutput(name, 32'(found), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base_lit;
        fb_grant = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Idle with an empty FIFO: nothing read, nothing written, address parked at 0.
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            checkOutput("idle rd_en", 32'(rd_o[0]), 32'd0);
            checkOutput("idle fb_we", 32'(we_o[0]), 32'd0);
            checkOutput("idle fb_addr", 32'(addr_o[0]), 32'd0);
        end

        // Streaming start: read, capture, then write two cycles after the first read.
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("first rd_en", 32'(rd_o[0]), 32'd1);
        checkOutput("first cycle fb_we", 32'(we_o[0]), 32'd0);
        @(negedge clk); #1;
        checkOutput("capture cycle fb_we", 32'(we_o[0]), 32'd0);
        @(negedge clk); #1;
        checkOutput("first write fb_we", 32'(we_o[0]), 32'd1);
        checkOutput("first write fb_data", 32'(data_o[0]), 32'd1);
        checkOutput("first write fb_addr", 32'(addr_o[0]), 32'd0);
        @(negedge clk); #1;
        checkOutput("second write fb_we", 32'(we_o[0]), 32'd1);
        checkOutput("second write fb_data", 32'(data_o[0]), 32'd2);
        checkOutput("second write fb_addr", 32'(addr_o[0]), 32'd1);
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);

        // Random grants and occasional empty FIFO.
        repeat (300) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), 1'b0);

        // Restart coincident with the write at address 1000.
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitWrite(0, 999, 1100, "reach addr 999");
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk); #1;
        checkOutput("restart write fb_we", 32'(we_o[0]), 32'd1);
        checkOutput("restart write fb_addr", 32'(addr_o[0]), 32'd1000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("after restart fb_we", 32'(we_o[0]), 32'd1);
        checkOutput("after restart fb_addr", 32'(addr_o[0]), 32'd0);

        // Full frame on the 8x4 instance: done pulses after address 31, next write at 0.
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitWrite(1, 31, 100, "reach small addr 31");
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("small frame_done", 32'(done_o[1]), 32'd1);
        checkOutput("small wrap fb_we", 32'(we_o[1]), 32'd1);
        checkOutput("small wrap fb_addr", 32'(addr_o[1]), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("small frame_done width", 32'(done_o[1]), 32'd0);
        checkOutput("small post-wrap fb_addr", 32'(addr_o[1]), 32'd1);

        // Restart landing on the last pixel still reports the frame.
        waitWrite(1, 30, 100, "reach small addr 30");
        applyStimulus(1'b1, 1'b0, 1'b1);
        @(negedge clk); #1;
        checkOutput("last pixel restart fb_addr", 32'(addr_o[1]), 32'd31);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk); #1;
        checkOutput("last pixel restart frame_done", 32'(done_o[1]), 32'd1);
        checkOutput("last pixel restart next fb_addr", 32'(addr_o[1]), 32'd0);

        // Fill the buffer with grants low, then reset with pixels buffered and in flight.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        base_lit = popped;
        @(negedge clk); #1;
        checkOutput("post-reset rd_en", 32'(rd_o[0]), 32'd1);
        checkOutput("post-reset fb_we", 32'(we_o[0]), 32'd0);
        @(negedge clk); #1;
        checkOutput("post-reset capture fb_we", 32'(we_o[0]), 32'd0);
        @(negedge clk); #1;
        checkOutput("post-reset write fb_we", 32'(we_o[0]), 32'd1);
        checkOutput("post-reset write fb_data", 32'(data_o[0]), 32'(color_of(base_lit)));
        checkOutput("post-reset write fb_addr", 32'(addr_o[0]), 32'd0);
        repeat (5) applyStimulus(1'b1, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/frame_buffer_fifo_drain.md
# frame_buffer_fifo_drain

Read side of the frame-buffer pixel FIFO. It pops 3-bit pixel colours that the rasterizer (or a test pattern source) pushed into the FIFO, and writes each colour into the frame-buffer RAM write port at a linear raster address. The address wraps at the end of every frame. It sits between the FIFO read port and the frame-buffer memory arbiter, and it sustains one pixel per clock while memory grants allow.

## Interface
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- COLOR_W, 3, pixel colour width
- ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W ≥ H_RES*V_RES

- clk  in  1  system clock, the single clock domain
- rst  in  1  asynchronous, active-low reset
- fifo_empty  in  1  FIFO empty flag
- fifo_dout  in  COLOR_W  FIFO read data; valid the cycle after fifo_rd_en (standard, non-first-word-fall-through)
- fifo_rd_en  out  1  FIFO pop request
- fb_grant  in  1  arbiter grants the frame-buffer write port this cycle
- fb_we  out  1  frame-buffer write strobe
- fb_addr  out  ADDR_W  write address, linear raster order (y*H_RES + x)
- fb_data  out  COLOR_W  write data
- frame_restart  in  1  single-cycle pulse; forces the next write to address 0
- frame_done  out  1  single-cycle pulse after the last pixel of a frame is written

## Operation
- Internal 2-entry pixel buffer; `count` ranges 0..2. `rd_pend` flag set when a FIFO read was issued in the previous cycle.
- `drain = (count>0) && fb_grant`.
- `fifo_rd_en = !fifo_empty && (count - drain + rd_pend) < 2`. This is combinational and is forced to 0 while rst is low.
- The cycle after fifo_rd_en, fifo_dout is captured into the buffer tail. Capture and drain may occur in the same cycle, leaving count unchanged.
- `fb_we = drain`, `fb_data = buffer head`, `fb_addr = addr_cnt`.
- After each write: addr_cnt increments. If addr_cnt was H_RES*V_RES-1, it wraps to 0 and frame_done is registered high for the next cycle.
- frame_restart sets addr_cnt to 0 on the next edge and does not touch buffer contents or the in-flight read.
  - If a write occurs in the same cycle, that write uses the old address and restart wins: addr_cnt becomes 0, not old+1.
  - If that write was the last pixel, frame_done still pulses.
- Buffer ordering is strictly FIFO. No pixel is dropped or duplicated under any pattern of fb_grant or fifo_empty.

## Timing
- Reset values (rst low, asynchronous): count=0, rd_pend=0, addr_cnt=0, fb_data=0, frame_done=0. Hence fifo_rd_en=0 and fb_we=0.
- Latency from fifo_rd_en high to the earliest fb_we for that pixel: 2 cycles (capture edge, then write with grant).
- Throughput: 1 pixel/cycle with fb_grant held high and FIFO non-empty.
- fb_grant low: no write, address holds. At most 2 pixels are buffered, and reads stall via fifo_rd_en.
- FIFO empty: fifo_rd_en is 0 and writes continue until the buffer is exhausted.
- Reset asserted mid-frame: all buffered and in-flight pixels are discarded and the address returns to 0. The FIFO itself is reset by its owner.

## Structure
- Shared display package holds H_RES, V_RES, COLOR_W, and FB_DEPTH = H_RES*V_RES. ADDR_W is derived there.
- One sub-module, `pixel_skid_buffer`: the 2-entry register FIFO with push, pop, count, and head outputs.
- The top level contains the read-pending flag, read-enable logic, address counter and frame_done register.

## Test plan
- Reset then release, FIFO empty, fb_grant=1 → fifo_rd_en=0, fb_we=0, fb_addr=0 for 20 cycles.
- Push colours 1,2,3,…,7 (repeating) continuously with fb_grant=1 → fb_we high every cycle from cycle 2 after the first read. fb_data follows the pushed order, fb_addr increments by 1 per write.
- Random fb_grant (50%) with FIFO always non-empty → never more than 2 reads outstanding unwritten. Written sequence equals read sequence and nothing is lost.
- Stream 307200 pixels at 640x480 → frame_done pulses exactly one cycle after the write at address 307199. The next write goes to address 0.
- frame_restart pulsed coincident with a write at address 1000 → that write lands at 1000 and the next write lands at 0.
- Assert rst with 2 pixels buffered and a read in flight → next write after release is the first newly popped pixel, at address 0.
